// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with clear, clamped load, wrap/saturate ends, wrap pulse and tally.
// Latency: count/wrap_pulse/wrap_cnt/load_err one clk edge after inputs; tc is combinational.
// Backpressure: none; a downstream stage throttles this one only through en.
module mod_n_updown_counter #(
  parameter int MODULUS    = 12,
  parameter int WIDTH      = 4,
  parameter int WRAP_MODE  = 1,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  en,
  input  logic                  up_dn,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
  output logic                  load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             at_end;
  logic             wrap_now;
  logic             clamp;
  logic [WIDTH-1:0] count_nxt;

  always_comb begin
    at_end    = up_dn ? (count == MAX_VAL) : (count == '0);
    tc        = en & ~clr & ~load & at_end;
    // In saturate mode tc still fires, but the end value is simply held.
    wrap_now  = tc & (WRAP_MODE != 0);
    clamp     = load_val > MAX_VAL;
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = clamp ? MAX_VAL : load_val;
    end else if (en) begin
      if (!at_end) begin
        count_nxt = up_dn ? count + ONE : count - ONE;
      end else if (WRAP_MODE != 0) begin
        count_nxt = up_dn ? '0 : MAX_VAL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      load_err   <= 1'b0;
    end else begin
      count      <= count_nxt;
      wrap_pulse <= wrap_now;
      load_err   <= ~clr & load & clamp;
      if (clr) begin
        wrap_cnt <= '0;
      end else if (wrap_now) begin
        wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
      end
    end
  end

endmodule
